// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state type, derived timing constants and BCD helpers for the alarm controller
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_e;

   function automatic int calc_tone_div(input int clk_hz, input int tone_hz);
      return clk_hz / (2 * tone_hz);
   endfunction

   function automatic int calc_beep_cyc(input int clk_hz, input int beep_ms);
      return clk_hz / 1000 * beep_ms;
   endfunction

   function automatic int calc_db_cyc(input int clk_hz, input int debounce_ms);
      return clk_hz / 1000 * debounce_ms;
   endfunction

   function automatic logic [7:0] bcd_pack(input logic [3:0] tens, input logic [3:0] ones);
      return {tens, ones};
   endfunction

   // width able to hold 0..max_val, never narrower than one bit
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizes and debounces an active-low pushbutton, pulses on each debounced press
module button_debounce
   import alarm_pkg::*;
#(
   parameter int DB_CYC = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic press
);

   localparam int              CW       = cnt_width(DB_CYC);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYC - 1);

   logic [1:0]    sync_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic          settle;

   // the level flips on the DB_CYC-th consecutive sample that disagrees with it
   assign settle = (sync_q[1] != level_q) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_n};
         press  <= settle && !sync_q[1];
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (settle) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - compares BCD time to the alarm setting and drives a gated buzzer tone with snooze and timeout
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int TONE_HZ     = 2000,
   parameter int BEEP_MS     = 250,
   parameter int DEBOUNCE_MS = 10,
   parameter int SNOOZE_MIN  = 5,
   parameter int MAX_SNOOZE  = 3,
   parameter int TIMEOUT_MIN = 10
) (
   input  logic       MAX10_CLK1_50,
   input  logic       KEY0,
   input  logic [3:0] HOUR_TEN,
   input  logic [3:0] HOUR_ONE,
   input  logic [3:0] MIN_TEN,
   input  logic [3:0] MIN_ONE,
   input  logic [3:0] SEC_TEN,
   input  logic [3:0] SEC_ONE,
   input  logic [7:0] a_hour,
   input  logic [7:0] a_min,
   input  logic       ALARM_EN,
   input  logic       SNOOZE_N,
   output logic       BUZZER,
   output logic       ALARM_ACTIVE,
   output logic       SNOOZED
);

   localparam int TONE_DIV = calc_tone_div(CLK_HZ, TONE_HZ);
   localparam int BEEP_CYC = calc_beep_cyc(CLK_HZ, BEEP_MS);
   localparam int DB_CYC   = calc_db_cyc(CLK_HZ, DEBOUNCE_MS);

   localparam int TD_W  = cnt_width(TONE_DIV);
   localparam int BC_W  = cnt_width(BEEP_CYC);
   localparam int RM_W  = cnt_width(TIMEOUT_MIN);
   localparam int REM_W = cnt_width(SNOOZE_MIN);
   localparam int SC_W  = cnt_width(MAX_SNOOZE);

   localparam logic [TD_W-1:0]  TONE_LAST = TD_W'(TONE_DIV - 1);
   localparam logic [BC_W-1:0]  BEEP_LAST = BC_W'(BEEP_CYC - 1);
   localparam logic [RM_W-1:0]  RING_LAST = RM_W'(TIMEOUT_MIN - 1);
   localparam logic [REM_W-1:0] REM_LOAD  = REM_W'(SNOOZE_MIN);
   localparam logic [SC_W-1:0]  SC_MAX    = SC_W'(MAX_SNOOZE);

   alarm_state_e     state_q;
   alarm_state_e     state_n;
   logic             match;
   logic             match_q;
   logic             match_q_d;
   logic             trig;
   logic [3:0]       prev_min_one;
   logic             tick;
   logic             press;
   logic [RM_W-1:0]  ring_min;
   logic [REM_W-1:0] rem;
   logic [SC_W-1:0]  snooze_cnt;
   logic             ring_start;
   logic             snooze_start;
   logic             ring_inc;
   logic             rem_dec;
   logic             clr_snooze;
   logic [TD_W-1:0]  tone_cnt;
   logic [BC_W-1:0]  beep_cnt;
   logic             tone_sq;
   logic             beep_on;
   logic             buzzer_q;

   button_debounce #(
      .DB_CYC (DB_CYC)
   ) u_snooze_db (
      .clk     (MAX10_CLK1_50),
      .reset_n (KEY0),
      .btn_n   (SNOOZE_N),
      .press   (press)
   );

   // non-BCD alarm settings simply never equal a real time digit pair
   assign match = ALARM_EN
                && (bcd_pack(HOUR_TEN, HOUR_ONE) == a_hour)
                && (bcd_pack(MIN_TEN, MIN_ONE) == a_min)
                && (SEC_TEN == 4'd0) && (SEC_ONE == 4'd0);
   assign trig  = match_q && !match_q_d;
   assign tick  = (MIN_ONE != prev_min_one);

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         match_q      <= 1'b0;
         match_q_d    <= 1'b0;
         prev_min_one <= 4'd0;
      end else begin
         match_q      <= match;
         match_q_d    <= match_q;
         prev_min_one <= MIN_ONE;
      end
   end

   always_comb begin
      state_n      = state_q;
      ring_start   = 1'b0;
      snooze_start = 1'b0;
      ring_inc     = 1'b0;
      rem_dec      = 1'b0;
      clr_snooze   = 1'b0;
      if (!ALARM_EN) begin
         state_n    = IDLE;
         clr_snooze = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (trig) begin
                  state_n    = RINGING;
                  ring_start = 1'b1;
                  clr_snooze = 1'b1;
               end
            end
            RINGING: begin
               // the timeout wins over a press landing on the same cycle
               if (tick && (ring_min == RING_LAST)) begin
                  state_n = IDLE;
               end else if (press && (snooze_cnt < SC_MAX)) begin
                  state_n      = SNOOZE;
                  snooze_start = 1'b1;
               end else if (press) begin
                  state_n = IDLE;
               end else if (tick) begin
                  ring_inc = 1'b1;
               end
            end
            SNOOZE: begin
               if (tick) begin
                  if (rem == REM_W'(1)) begin
                     state_n    = RINGING;
                     ring_start = 1'b1;
                  end else begin
                     rem_dec = 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         state_q    <= IDLE;
         ring_min   <= '0;
         rem        <= '0;
         snooze_cnt <= '0;
      end else begin
         state_q <= state_n;
         if (clr_snooze) begin
            snooze_cnt <= '0;
         end else if (snooze_start) begin
            snooze_cnt <= snooze_cnt + 1'b1;
         end
         if (ring_start) begin
            ring_min <= '0;
         end else if (ring_inc) begin
            ring_min <= ring_min + 1'b1;
         end
         if (snooze_start) begin
            rem <= REM_LOAD;
         end else if (rem_dec) begin
            rem <= rem - 1'b1;
         end
      end
   end

   // tone and cadence restart from a known phase on every entry to ringing
   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         tone_cnt <= '0;
         beep_cnt <= '0;
         tone_sq  <= 1'b0;
         beep_on  <= 1'b0;
         buzzer_q <= 1'b0;
      end else begin
         if (ring_start) begin
            tone_cnt <= '0;
            beep_cnt <= '0;
            tone_sq  <= 1'b0;
            beep_on  <= 1'b1;
         end else if (state_q == RINGING) begin
            if (tone_cnt == TONE_LAST) begin
               tone_cnt <= '0;
               tone_sq  <= !tone_sq;
            end else begin
               tone_cnt <= tone_cnt + 1'b1;
            end
            if (beep_cnt == BEEP_LAST) begin
               beep_cnt <= '0;
               beep_on  <= !beep_on;
            end else begin
               beep_cnt <= beep_cnt + 1'b1;
            end
         end
         buzzer_q <= (state_q == RINGING) && beep_on && tone_sq;
      end
   end

   assign BUZZER       = buzzer_q;
   assign ALARM_ACTIVE = (state_q == RINGING);
   assign SNOOZED      = (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed and randomized checks of alarm_controller against an event-level model
module tb_alarm_controller;

   localparam int T_SNOOZE_MIN  = 2;
   localparam int T_MAX_SNOOZE  = 1;
   localparam int T_TIMEOUT_MIN = 3;

   logic       clk = 1'b0;
   logic       KEY0;
   logic [3:0] HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE;
   logic [7:0] a_hour, a_min;
   logic       ALARM_EN, SNOOZE_N;
   logic       BUZZER, ALARM_ACTIVE, SNOOZED;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // event-level model: 0 idle, 1 ringing, 2 snoozed
   int m_mode, m_ring_min, m_snoozes, m_rem;

   alarm_controller #(
      .CLK_HZ      (1000),
      .TONE_HZ     (100),
      .BEEP_MS     (20),
      .DEBOUNCE_MS (3),
      .SNOOZE_MIN  (T_SNOOZE_MIN),
      .MAX_SNOOZE  (T_MAX_SNOOZE),
      .TIMEOUT_MIN (T_TIMEOUT_MIN)
   ) dut (
      .MAX10_CLK1_50 (clk),
      .KEY0          (KEY0),
      .HOUR_TEN      (HOUR_TEN),
      .HOUR_ONE      (HOUR_ONE),
      .MIN_TEN       (MIN_TEN),
      .MIN_ONE       (MIN_ONE),
      .SEC_TEN       (SEC_TEN),
      .SEC_ONE       (SEC_ONE),
      .a_hour        (a_hour),
      .a_min         (a_min),
      .ALARM_EN      (ALARM_EN),
      .SNOOZE_N      (SNOOZE_N),
      .BUZZER        (BUZZER),
      .ALARM_ACTIVE  (ALARM_ACTIVE),
      .SNOOZED       (SNOOZED)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      {HOUR_TEN, HOUR_ONE} = h;
      {MIN_TEN, MIN_ONE}   = m;
      {SEC_TEN, SEC_ONE}   = s;
   endtask

   task automatic model_tick();
      if (m_mode == 1) begin
         if (m_ring_min == T_TIMEOUT_MIN - 1) m_mode = 0;
         else m_ring_min++;
      end else if (m_mode == 2) begin
         m_rem--;
         if (m_rem == 0) begin
            m_mode     = 1;
            m_ring_min = 0;
         end
      end
   endtask

   task automatic model_press();
      if (m_mode == 1) begin
         if (m_snoozes < T_MAX_SNOOZE) begin
            m_mode = 2;
            m_snoozes++;
            m_rem = T_SNOOZE_MIN;
         end else begin
            m_mode = 0;
         end
      end
   endtask

   task automatic tick_min();
      MIN_ONE = (MIN_ONE == 4'd9) ? 4'd0 : MIN_ONE + 4'd1;
      cyc(3);
      model_tick();
   endtask

   task automatic press_btn(input int lo);
      SNOOZE_N = 1'b0;
      cyc(lo);
      SNOOZE_N = 1'b1;
      cyc(8);
      model_press();
   endtask

   // fresh 06:29:59 -> 06:30:00 edge, then the seconds move on so it cannot match again
   task automatic trigger_ring();
      ALARM_EN = 1'b0;
      set_time(8'h06, 8'h29, 8'h59);
      cyc(2);
      ALARM_EN = 1'b1;
      cyc(1);
      set_time(8'h06, 8'h30, 8'h00);
      cyc(2);
      SEC_ONE = 4'd1;
      cyc(1);
      m_mode = 1; m_ring_min = 0; m_snoozes = 0; m_rem = 0;
   endtask

   initial begin
      int exp_bz;
      int found;
      KEY0 = 1'b0; SNOOZE_N = 1'b1; ALARM_EN = 1'b0;
      a_hour = 8'h06; a_min = 8'h30;
      set_time(8'h00, 8'h00, 8'h00);
      cyc(3);
      check("reset_buzzer", BUZZER, 0);
      check("reset_active", ALARM_ACTIVE, 0);
      check("reset_snoozed", SNOOZED, 0);
      KEY0 = 1'b1;

      // trigger latency and tone/cadence shape
      ALARM_EN = 1'b1;
      set_time(8'h06, 8'h29, 8'h59);
      cyc(3);
      set_time(8'h06, 8'h30, 8'h00);
      cyc(1);
      check("trig_edge1", ALARM_ACTIVE, 0);
      cyc(1);
      check("trig_edge2", ALARM_ACTIVE, 1);
      check("buzzer_n0", BUZZER, 0);
      for (int n = 1; n < 45; n++) begin
         cyc(1);
         exp_bz = ((((n - 1) / 5) % 2) == 1 && (((n - 1) / 20) % 2) == 0) ? 1 : 0;
         check($sformatf("buzzer_n%0d", n), BUZZER, exp_bz);
      end

      // disable wins, then re-raising the enable re-triggers on the same time
      ALARM_EN = 1'b0;
      cyc(1);
      check("disable_idle", ALARM_ACTIVE, 0);
      cyc(1);
      check("disable_buzzer", BUZZER, 0);
      cyc(1);
      ALARM_EN = 1'b1;
      cyc(1);
      check("reen_edge1", ALARM_ACTIVE, 0);
      cyc(1);
      check("reen_edge2", ALARM_ACTIVE, 1);
      SEC_ONE = 4'd1;
      cyc(1);

      // short glitch ignored, a 4-cycle press snoozes
      SNOOZE_N = 1'b0;
      cyc(2);
      SNOOZE_N = 1'b1;
      cyc(10);
      check("glitch_active", ALARM_ACTIVE, 1);
      check("glitch_snoozed", SNOOZED, 0);
      press_btn(4);
      check("snooze_state", SNOOZED, 1);
      check("snooze_active", ALARM_ACTIVE, 0);
      check("snooze_buzzer", BUZZER, 0);
      tick_min();
      check("snooze_tick1", SNOOZED, 1);
      tick_min();
      check("snooze_resume", ALARM_ACTIVE, 1);
      check("snooze_resume_sn", SNOOZED, 0);
      press_btn(5);
      check("limit_dismiss", ALARM_ACTIVE, 0);
      check("limit_dismiss_sn", SNOOZED, 0);

      // timeout after TIMEOUT_MIN ticks
      trigger_ring();
      check("to_start", ALARM_ACTIVE, 1);
      tick_min();
      tick_min();
      check("to_tick2", ALARM_ACTIVE, 1);
      tick_min();
      check("to_tick3", ALARM_ACTIVE, 0);

      // press landing on the timeout tick
      trigger_ring();
      tick_min();
      tick_min();
      SNOOZE_N = 1'b0;
      cyc(5);
      MIN_ONE = (MIN_ONE == 4'd9) ? 4'd0 : MIN_ONE + 4'd1;
      cyc(1);
      check("to_press_active", ALARM_ACTIVE, 0);
      check("to_press_snoozed", SNOOZED, 0);
      SNOOZE_N = 1'b1;
      cyc(10);
      check("to_press_after", SNOOZED, 0);

      // asynchronous reset mid-ring
      trigger_ring();
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         cyc(1);
         if (BUZZER === 1'b1) found = 1;
      end
      check("buzzer_seen", found, 1);
      #1 KEY0 = 1'b0;
      #1;
      check("areset_buzzer", BUZZER, 0);
      check("areset_active", ALARM_ACTIVE, 0);
      check("areset_snoozed", SNOOZED, 0);
      @(negedge clk);
      KEY0 = 1'b1;
      cyc(20);
      check("no_ring_after_reset", ALARM_ACTIVE, 0);
      trigger_ring();
      check("ring_after_new_edge", ALARM_ACTIVE, 1);

      // randomized tick/press sequences against the model
      for (int r = 0; r < 4; r++) begin
         trigger_ring();
         for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 2) press_btn($urandom_range(4, 7));
            else tick_min();
            check($sformatf("rand%0d_%0d_active", r, k), ALARM_ACTIVE, (m_mode == 1) ? 1 : 0);
            check($sformatf("rand%0d_%0d_snoozed", r, k), SNOOZED, (m_mode == 2) ? 1 : 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
